// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: default widths, ALU control
// codes and the arbiter state encoding.
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_OP_WIDTH   = 3;

  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_AND = 3'b000;
  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_OR  = 3'b001;
  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_ADD = 3'b010;
  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_SUB = 3'b100;
  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_MUL = 3'b101;
  localparam logic [DEFAULT_OP_WIDTH-1:0] OP_SLT = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU. Arithmetic wraps modulo 2^DATA_WIDTH, SLT is
// unsigned, and unknown control codes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OP_WIDTH   = DEFAULT_OP_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OP_WIDTH-1:0]   op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  // Decode the control code into the selected operation.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // result unassigned, which would otherwise infer a latch.
    result = '0;
    case (op)
      OP_WIDTH'(OP_AND): result = a & b;
      OP_WIDTH'(OP_OR):  result = a | b;
      OP_WIDTH'(OP_ADD): result = a + b;
      OP_WIDTH'(OP_SUB): result = a - b;
      OP_WIDTH'(OP_MUL): result = a * b;
      OP_WIDTH'(OP_SLT): result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default:           result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// One operation in flight: IDLE (grant) -> EXEC (evaluate) -> RESP (hold
// result until the owner accepts it).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OP_WIDTH   = DEFAULT_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [OP_WIDTH-1:0]   req1_op,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic                  busy
);

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  grant0;
  logic                  grant1;
  logic                  owner_rsp_ready;

  alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .OP_WIDTH  (OP_WIDTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(alu_result),
    .zero  (alu_zero)
  );

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not
  // served last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready      = (state == ST_IDLE) && grant0;
  assign req1_ready      = (state == ST_IDLE) && grant1;
  assign rsp0_valid      = (state == ST_RESP) && !owner;
  assign rsp1_valid      = (state == ST_RESP) && owner;
  assign busy            = (state != ST_IDLE);
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  // Arbiter FSM with operand latches and registered ALU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments throughout so every register samples
      // the pre-edge values regardless of statement order.
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      // NOTE: operand latches are reset too, so the ALU never evaluates
      // unknown values after reset even though nothing observes them.
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner      <= grant1;
            last_grant <= grant1;
            a_q        <= grant1 ? req1_a  : req0_a;
            b_q        <= grant1 ? req1_b  : req0_b;
            op_q       <= grant1 ? req1_op : req0_op;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses,
// an independent monitor pops and compares whenever a response is shown.
module tb_alu_arbiter;

  localparam int DW = 32;

  typedef struct {
    logic          port;
    logic [DW-1:0] result;
    logic          zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic port, input logic [DW-1:0] result, input logic zero);
    exp_t e;
    e.port   = port;
    e.result = result;
    e.zero   = zero;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per response and checks it on every
  // cycle the response is held.
  initial begin
    exp_t cur;
    bit   cur_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_valid = 1'b0;
      end else if (rsp0_valid || rsp1_valid) begin
        if (!cur_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got response result 0x%0h expected none", rsp_result);
          end else begin
            cur       = sb.pop_front();
            cur_valid = 1'b1;
          end
        end
        if (cur_valid) begin
          check("rsp_port", {62'd0, rsp1_valid, rsp0_valid}, cur.port ? 64'd2 : 64'd1);
          check("rsp_result", rsp_result, cur.result);
          check("rsp_zero", rsp_zero, cur.zero);
        end
      end else begin
        cur_valid = 1'b0;
      end
    end
  end

  // Drive phase is posedge+1; sampling happens at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic port, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op);
    bit got = 1'b0;
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? req1_ready : req0_ready;
      if (!got) tick();
    end
    if (!got) check("accept_timeout", {63'd0, got}, 64'd1);
    tick();
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  // Leaves the caller at a negedge where the response is visible.
  task automatic wait_rsp(input logic port);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? rsp1_valid : rsp0_valid;
    end
    if (!got) check("rsp_timeout", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = !busy && (sb.size() == 0);
    end
    if (!done) check("idle_timeout", {63'd0, done}, 64'd1);
    tick();
  endtask

  // Both requesters hold valid; expects alternating grants starting with
  // req0, spaced exactly 3 cycles apart.
  task automatic run_both(input int n_target);
    int n    = 0;
    int last = 0;
    for (int cyc = 0; cyc < 60 && n < n_target; cyc++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("alt_grant", {62'd0, req1_ready, req0_ready}, (n % 2) ? 64'd2 : 64'd1);
        if (n > 0) check("alt_gap", cyc - last, 3);
        last = cyc;
        n++;
      end
      tick();
      if (n == n_target) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    check("alt_count", n, n_target);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    check("rst_zero", rsp_zero, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    tick();
    rst = 1'b0;

    // req0 ADD 5+7 with explicit latency checks
    push(1'b0, 32'd12, 1'b0);
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 3'b010;
    @(negedge clk);
    check("lat_n_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("lat_n1_busy", busy, 1);
    check("lat_n1_rsp0", rsp0_valid, 0);
    tick();
    @(negedge clk);
    check("lat_n2_rsp0", rsp0_valid, 1);
    check("lat_n2_rsp1", rsp1_valid, 0);
    tick();
    @(negedge clk);
    check("lat_n3_idle", busy, 0);
    tick();

    // req1 SUB 9-9 then MUL with wrap
    push(1'b1, 32'd0, 1'b1);
    issue(1'b1, 32'd9, 32'd9, 3'b100);
    wait_idle();
    push(1'b1, 32'd0, 1'b1);
    issue(1'b1, 32'h0001_0000, 32'h0001_0000, 3'b101);
    wait_idle();

    // Both valid continuously: strict alternation 0,1,0,1
    push(1'b0, 32'h30, 1'b0);
    push(1'b1, 32'hFF, 1'b0);
    push(1'b0, 32'h30, 1'b0);
    push(1'b1, 32'hFF, 1'b0);
    req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b001;
    run_both(4);
    wait_idle();

    // Undefined op; only the non-owner offers rsp_ready
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    push(1'b0, 32'd0, 1'b1);
    issue(1'b0, 32'd5, 32'd6, 3'b111);
    wait_rsp(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("undef_hold_valid", rsp0_valid, 1);
      check("undef_hold_busy", busy, 1);
    end
    tick();
    rsp0_ready = 1'b1;
    wait_idle();

    // Backpressure: SLT 3<4 held for 5 cycles while req1 waits
    rsp0_ready = 1'b0;
    push(1'b0, 32'd1, 1'b0);
    issue(1'b0, 32'd3, 32'd4, 3'b110);
    push(1'b1, 32'd2, 1'b0);
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b010;
    wait_rsp(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_result", rsp_result, 1);
      check("bp_busy", busy, 1);
      check("bp_req1_ready", req1_ready, 0);
    end
    tick();
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", rsp0_valid, 1);
    tick();
    @(negedge clk);
    check("bp_release_idle", busy, 0);
    check("bp_release_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    wait_idle();

    // Reset during EXEC: op discarded, outputs reset, next tie to req0
    issue(1'b0, 32'd1, 32'd2, 3'b010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("mid_rst_result", rsp_result, 0);
    check("mid_rst_zero", rsp_zero, 0);
    tick();
    push(1'b0, 32'h0F, 1'b0);
    push(1'b1, 32'h00, 1'b1);
    req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 32'h00; req1_b = 32'h00; req1_op = 3'b001;
    run_both(2);
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU instance between two requesters (for example, the core's integer path and a coprocessor/debug port) using valid/ready handshakes. The block grants requests round-robin, latches the operands and ALU control, and evaluates the ALU for one cycle. It then holds a registered result and zero flag until the granted requester accepts them. Only one operation is in flight at a time.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OP_WIDTH`, 3, ALU control width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  requester i has an operation
- `req0_ready` / `req1_ready`  out  1  block accepts requester i's operation this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands
- `req0_op` / `req1_op`  in  OP_WIDTH  ALU control code
- `rsp0_valid` / `rsp1_valid`  out  1  result available for requester i
- `rsp0_ready` / `rsp1_ready`  in  1  requester i takes the result
- `rsp_result`  out  DATA_WIDTH  registered ALU output, shared by both response ports
- `rsp_zero`  out  1  registered zero flag
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant selection:
    - If only one `reqi_valid` is high, grant that requester.
    - If both are high, grant the requester that is not `last_grant`.
  - `reqi_ready` is asserted combinationally for the granted requester only, and only in IDLE.
  - On `valid&&ready`: latch a, b, op and the owner; set `last_grant`=owner; go to EXEC.
- **EXEC**
  - The ALU sees the latched operands.
  - The ALU output and zero flag are registered into `rsp_result`/`rsp_zero`.
  - Next state is RESP.
- **RESP**
  - `rspi_valid` is high for the owner only.
  - Result and flag are held stable.
  - On `rspi_ready` for the owner: return to IDLE.
  - A `rsp_ready` from the non-owner is ignored.
- ALU codes:
  - AND=000, OR=001, ADD=010, SUB=100, MUL=101, SLT=110.
  - Any other code gives result 0 and zero=1.
  - ADD/SUB/MUL wrap modulo 2^DATA_WIDTH; MUL keeps the low DATA_WIDTH bits.
  - SLT is an unsigned compare.
- Requests arriving while not in IDLE see ready=0 and must hold (standard valid/ready; requesters must not drop valid before handshake).
- A requester whose response is pending can also hold a new request. It is serviced only after its response completes and, if the other requester is waiting, after the other requester is served.

## Timing
- Reset values:
  - State IDLE; `last_grant`=1, so req0 wins the first tie.
  - `rsp_result`=0, `rsp_zero`=0; all ready/valid outputs 0; `busy`=0.
- Latency: accept in cycle N, EXEC in N+1, `rspi_valid` high in N+2.
- With `rsp_ready` tied high, a new accept is possible in N+3, giving a minimum of 3 cycles per operation.
- Back-to-back requests from both sides with `rsp_ready` high alternate 0,1,0,1.
- `rst` mid-operation: the in-flight operation is discarded, there is no response, and all outputs return to their reset values on the next edge.
- `reqi_ready` depends combinationally on `reqi_valid`. Requesters must not make `valid` depend on `ready`.

## Structure
- Shared package `alu_pkg`:
  - ALU control code constants (AND, OR, ADD, SUB, MUL, SLT).
  - FSM state encoding (2 bits).
  - `DATA_WIDTH`/`OP_WIDTH` defaults.
- One sub-module: the existing `ALU`, instantiated once with the latched operands. The arbiter FSM, grant logic and result registers live in `alu_arbiter` itself.

## Test plan
- Reset, then req0 ADD a=5, b=7 -> accept at N, `rsp0_valid` at N+2 with `rsp_result`=12, `rsp_zero`=0; `rsp1_valid` stays 0.
- req1 SUB a=9, b=9 -> `rsp1_valid`, result 0, zero=1; then req1 MUL a=0x10000, b=0x10000 -> result 0 (wrap), zero=1.
- Both valid every cycle, `rsp_ready` high: req0 AND 0xF0&0x3C=0x30, then req1 OR 0xF0|0x0F=0xFF, then req0 again -> strict alternation, each granted exactly once per 6 cycles.
- Backpressure: req0 SLT a=3, b=4 with `rsp0_ready` low for 5 cycles -> `rsp0_valid` held, result 1 stable, `busy`=1, `req1_ready`=0 throughout; release -> IDLE next cycle.
- Undefined op 3'b111 -> result 0, zero=1; `rsp_ready` asserted by the non-owner only -> no completion.
- Assert `rst` during EXEC -> next cycle all outputs at reset values, no `rsp_valid`; the following tie grants req0.
